// File: rtl/fp_subtractor_pipe.sv
// fp_subtractor_pipe: three-stage truncating IEEE-754 single-precision subtractor with valid/ready flow control.
module fp_subtractor_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int E = 8,
    parameter int M = 23
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out
);
    localparam int W = 2 * M + 2;
    localparam int LZW = $clog2(W);
    localparam logic [E-1:0] EMAX = '1;
    localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M - 1){1'b0}}};

    logic v1_q, v2_q, v3_q;
    logic adv1, adv2, adv3;
    logic sp1_q, s1_q, sub1_q;
    logic [E-1:0] e1_q;
    logic [W-1:0] ml1_q, ms1_q;
    logic sp2_q, s2_q;
    logic [E-1:0] e2_q;
    logic [W-1:0] r2_q;
    logic [DATA_WIDTH-1:0] out_q;

    assign adv3 = ~v3_q | out_ready;
    assign adv2 = ~v2_q | adv3;
    assign adv1 = ~v1_q | adv2;
    assign in_ready = adv1;
    assign out_valid = v3_q;
    assign out = out_q;

    logic a_s, b_s, a_big;
    logic [E-1:0] a_e, b_e, dif;
    logic [M-1:0] a_m, b_m;
    logic [W-1:0] a_x, b_x;
    logic sp1_d, s1_d, sub1_d;
    logic [E-1:0] e1_d;
    logic [W-1:0] ml1_d, ms1_d;

    // Align: b_s is the subtrahend sign already inverted, so the rest is a plain add.
    always_comb begin
        a_s = in1[DATA_WIDTH-1];
        b_s = ~in2[DATA_WIDTH-1];
        a_e = in1[DATA_WIDTH-2 -: E];
        b_e = in2[DATA_WIDTH-2 -: E];
        a_m = in1[M-1:0];
        b_m = in2[M-1:0];
        a_x = (a_e == '0) ? '0 : {2'b01, a_m, {M{1'b0}}};
        b_x = (b_e == '0) ? '0 : {2'b01, b_m, {M{1'b0}}};
        a_big = {a_e, a_m} >= {b_e, b_m};
        dif = a_big ? a_e - b_e : b_e - a_e;
        sp1_d = (a_e == EMAX) || (b_e == EMAX);
        s1_d = a_big ? a_s : b_s;
        sub1_d = a_s ^ b_s;
        e1_d = a_big ? a_e : b_e;
        ml1_d = a_big ? a_x : b_x;
        ms1_d = (a_big ? b_x : a_x) >> dif;
    end

    logic [W-1:0] r2_d;

    always_comb begin
        r2_d = sub1_q ? ml1_q - ms1_q : ml1_q + ms1_q;
    end

    logic [LZW-1:0] lz;
    logic [W-1:0] norm;
    logic [E+1:0] en;
    logic [DATA_WIDTH-1:0] out_d;

    // Leading one lands at bit W-1 after the shift; the hidden bit is dropped on pack.
    always_comb begin
        lz = '0;
        for (int i = 0; i < W; i++)
            if (r2_q[i]) lz = LZW'(W - 1 - i);
        norm = r2_q << lz;
        en = {2'b00, e2_q} + (E + 2)'(1) - {{(E + 2 - LZW){1'b0}}, lz};
        out_d = sp2_q ? QNAN :
                (r2_q == '0) ? '0 :
                (en[E+1] || en == '0) ? {s2_q, {(DATA_WIDTH - 1){1'b0}}} :
                (en >= {2'b00, EMAX}) ? {s2_q, EMAX, {M{1'b0}}} :
                {s2_q, en[E-1:0], norm[W-2 -: M]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            out_q <= '0;
        end else begin
            if (adv1) v1_q <= in_valid;
            if (adv2) v2_q <= v1_q;
            if (adv3) v3_q <= v2_q;
            if (adv3 && v2_q) out_q <= out_d;
        end
    end

    // Payload registers only load alongside a valid token, so idle bubbles never disturb them.
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            sp1_q <= sp1_d;
            s1_q <= s1_d;
            sub1_q <= sub1_d;
            e1_q <= e1_d;
            ml1_q <= ml1_d;
            ms1_q <= ms1_d;
        end
        if (adv2 && v1_q) begin
            sp2_q <= sp1_q;
            s2_q <= s1_q;
            e2_q <= e1_q;
            r2_q <= r2_d;
        end
    end
endmodule
